fp_issue_ctl: RTL and testbench

Single-outstanding issue controller between decode pipe i0 and the FP unit. Accepts one decoded FP packet (add/sub/mul/div) at a time, maps it to the FPU opcode and operand slots, runs the FPU valid/ready handshakes, and returns a one-cycle writeback with accumulated sticky exception flags. Decode holds further FP instructions off through `fp_busy`, which gives FP ops presync/postsync behaviour. Also handles flush and a hang watchdog.

---
 rtl/fp_issue_ctl.sv | 170 +++++++++++++++++
 tb/tb_fp_issue_ctl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_issue_ctl.sv
// rtl/fp_issue_ctl.sv - single-outstanding FP issue controller between decode i0 and the FPU
//
// Ports:
//   clk, rst             core clock, asynchronous active-high reset
//   dec_fp_*             decoded FP packet offered by decode ({add, mul, div, sub} one-hot)
//   dec_frm              rounding mode for the offered instruction
//   flush                pipeline flush, kills any in-flight op
//   fflags_clr           clears the sticky exception flags
//   fpu_in_valid/ready   issue handshake; fpu_op/op_mod/rnd/opa/opb/opc are held while valid
//   fpu_out_valid/ready  completion handshake carrying fpu_result/fpu_status
//   fpu_flush            one-cycle FPU kill pulse (flush or watchdog)
//   fp_busy              decode stall while an op is outstanding
//   fp_wb_valid/rd/data  one-cycle writeback
//   fp_illegal           malformed packet pulse
//   fp_timeout           watchdog pulse
//   fflags               sticky {NV,DZ,OF,UF,NX}
module fp_issue_ctl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_fp_valid,
  input  logic [3:0]  dec_fp_pkt,
  input  logic [4:0]  dec_fp_rd,
  input  logic [31:0] dec_fp_rs1,
  input  logic [31:0] dec_fp_rs2,
  input  logic [2:0]  dec_frm,
  input  logic        flush,
  input  logic        fflags_clr,
  output logic        fpu_in_valid,
  input  logic        fpu_in_ready,
  output logic [3:0]  fpu_op,
  output logic        fpu_op_mod,
  output logic [2:0]  fpu_rnd,
  output logic [31:0] fpu_opa,
  output logic [31:0] fpu_opb,
  output logic [31:0] fpu_opc,
  input  logic        fpu_out_valid,
  output logic        fpu_out_ready,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_status,
  output logic        fpu_flush,
  output logic        fp_busy,
  output logic        fp_wb_valid,
  output logic [4:0]  fp_wb_rd,
  output logic [31:0] fp_wb_data,
  output logic        fp_illegal,
  output logic        fp_timeout,
  output logic [4:0]  fflags
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic [1:0]    state_d;
  logic [CW-1:0] wd_cnt;
  logic [4:0]    rd_q;

  logic          active;
  logic          pkt_onehot;
  logic          accept;
  logic          bad_pkt;
  logic          out_hs;
  logic          capture;
  logic          wd_expire;

  logic [3:0]    op_d;
  logic          mod_d;
  logic [31:0]   opa_d;
  logic [31:0]   opb_d;
  logic [31:0]   opc_d;

  assign active     = (state != S_IDLE);
  assign pkt_onehot = $onehot(dec_fp_pkt);
  assign accept     = (state == S_IDLE) && dec_fp_valid && pkt_onehot && !flush;
  assign bad_pkt    = (state == S_IDLE) && dec_fp_valid && !pkt_onehot && !flush;
  assign out_hs     = (state == S_BUSY) && fpu_out_valid;
  // A flush landing on the completion cycle discards the result.
  assign capture    = out_hs && !flush;
  // A completion on the last allowed cycle beats the watchdog; flush beats both.
  assign wd_expire  = active && (wd_cnt == CNT_LAST) && !out_hs && !flush;

  // Handshake qualifiers come straight from registered state.
  assign fpu_in_valid  = (state == S_ISSUE);
  assign fpu_out_ready = (state == S_BUSY);
  assign fp_busy       = active;

  // Opcode and operand-slot mapping; add/sub use slots 1/2, mul/div use slots 0/1.
  always_comb begin
    op_d  = 4'd2;
    mod_d = 1'b0;
    opa_d = 32'd0;
    opb_d = dec_fp_rs1;
    opc_d = dec_fp_rs2;
    if (dec_fp_pkt[0]) begin
      mod_d = 1'b1;
    end else if (dec_fp_pkt[2] || dec_fp_pkt[1]) begin
      op_d  = dec_fp_pkt[2] ? 4'd3 : 4'd4;
      opa_d = dec_fp_rs1;
      opb_d = dec_fp_rs2;
      opc_d = 32'd0;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: begin
        if (flush || wd_expire) state_d = S_IDLE;
        else if (fpu_in_ready)  state_d = S_BUSY;
      end
      S_BUSY:  if (flush || wd_expire || out_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wd_cnt      <= '0;
      rd_q        <= 5'd0;
      fpu_op      <= 4'd0;
      fpu_op_mod  <= 1'b0;
      fpu_rnd     <= 3'd0;
      fpu_opa     <= 32'd0;
      fpu_opb     <= 32'd0;
      fpu_opc     <= 32'd0;
      fpu_flush   <= 1'b0;
      fp_wb_valid <= 1'b0;
      fp_wb_rd    <= 5'd0;
      fp_wb_data  <= 32'd0;
      fp_illegal  <= 1'b0;
      fp_timeout  <= 1'b0;
      fflags      <= 5'd0;
    end else begin
      state       <= state_d;
      fp_wb_valid <= capture;
      fp_illegal  <= bad_pkt;
      fp_timeout  <= wd_expire;
      fpu_flush   <= (active && flush) || wd_expire;
      fflags      <= (fflags_clr ? 5'd0 : fflags) | (capture ? fpu_status : 5'd0);

      // Counter runs only while an op is outstanding and restarts from zero on every accept.
      if (state_d == S_IDLE) wd_cnt <= '0;
      else if (active)       wd_cnt <= wd_cnt + 1'b1;

      if (accept) begin
        rd_q       <= dec_fp_rd;
        fpu_op     <= op_d;
        fpu_op_mod <= mod_d;
        fpu_rnd    <= dec_frm;
        fpu_opa    <= opa_d;
        fpu_opb    <= opb_d;
        fpu_opc    <= opc_d;
      end

      if (capture) begin
        fp_wb_rd   <= rd_q;
        fp_wb_data <= fpu_result;
      end
    end
  end

endmodule

// File: tb/tb_fp_issue_ctl.sv
// tb/tb_fp_issue_ctl.sv - directed self-checking bench for fp_issue_ctl
module tb_fp_issue_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_fp_valid;
  logic [3:0]  dec_fp_pkt;
  logic [4:0]  dec_fp_rd;
  logic [31:0] dec_fp_rs1;
  logic [31:0] dec_fp_rs2;
  logic [2:0]  dec_frm;
  logic        flush;
  logic        fflags_clr;
  logic        fpu_in_valid;
  logic        fpu_in_ready;
  logic [3:0]  fpu_op;
  logic        fpu_op_mod;
  logic [2:0]  fpu_rnd;
  logic [31:0] fpu_opa;
  logic [31:0] fpu_opb;
  logic [31:0] fpu_opc;
  logic        fpu_out_valid;
  logic        fpu_out_ready;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_status;
  logic        fpu_flush;
  logic        fp_busy;
  logic        fp_wb_valid;
  logic [4:0]  fp_wb_rd;
  logic [31:0] fp_wb_data;
  logic        fp_illegal;
  logic        fp_timeout;
  logic [4:0]  fflags;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_fflags = 5'd0;

  localparam logic [3:0] P_ADD = 4'b1000;
  localparam logic [3:0] P_MUL = 4'b0100;
  localparam logic [3:0] P_DIV = 4'b0010;
  localparam logic [3:0] P_SUB = 4'b0001;

  fp_issue_ctl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .dec_fp_valid(dec_fp_valid), .dec_fp_pkt(dec_fp_pkt), .dec_fp_rd(dec_fp_rd),
    .dec_fp_rs1(dec_fp_rs1), .dec_fp_rs2(dec_fp_rs2), .dec_frm(dec_frm),
    .flush(flush), .fflags_clr(fflags_clr),
    .fpu_in_valid(fpu_in_valid), .fpu_in_ready(fpu_in_ready),
    .fpu_op(fpu_op), .fpu_op_mod(fpu_op_mod), .fpu_rnd(fpu_rnd),
    .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_opc(fpu_opc),
    .fpu_out_valid(fpu_out_valid), .fpu_out_ready(fpu_out_ready),
    .fpu_result(fpu_result), .fpu_status(fpu_status),
    .fpu_flush(fpu_flush), .fp_busy(fp_busy),
    .fp_wb_valid(fp_wb_valid), .fp_wb_rd(fp_wb_rd), .fp_wb_data(fp_wb_data),
    .fp_illegal(fp_illegal), .fp_timeout(fp_timeout), .fflags(fflags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected $finish");
    $fatal(1);
  end

  typedef struct packed {
    logic [3:0]  pkt;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  frm;
    logic [31:0] res;
    logic [4:0]  st;
    logic        ill;
    logic [3:0]  op;
    logic        mod;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] opc;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %0s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] pkt, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] frm, input logic clr);
    dec_fp_valid = 1'b1;
    dec_fp_pkt   = pkt;
    dec_fp_rd    = rd;
    dec_fp_rs1   = a;
    dec_fp_rs2   = b;
    dec_frm      = frm;
    fflags_clr   = clr;
    step();
    dec_fp_valid = 1'b0;
    fflags_clr   = 1'b0;
    if (clr) exp_fflags = 5'd0;
  endtask

  // Starts in ISSUE; grants ready, waits wait_n BUSY cycles, then returns the result.
  task automatic complete(input logic [31:0] res, input logic [4:0] st, input logic clr,
                          input logic [4:0] rd, input int wait_n);
    fpu_in_ready = 1'b1;
    step();
    chk("busy_out_ready", fpu_out_ready, 1'b1);
    chk("busy_in_valid_low", fpu_in_valid, 1'b0);
    repeat (wait_n) step();
    fpu_out_valid = 1'b1;
    fpu_result    = res;
    fpu_status    = st;
    fflags_clr    = clr;
    step();
    fpu_out_valid = 1'b0;
    fflags_clr    = 1'b0;
    exp_fflags    = (clr ? 5'd0 : exp_fflags) | st;
    chk("wb_valid", fp_wb_valid, 1'b1);
    chk("wb_rd", fp_wb_rd, rd);
    chk("wb_data", fp_wb_data, res);
    chk("wb_fflags", fflags, exp_fflags);
    chk("wb_busy_low", fp_busy, 1'b0);
    chk("wb_no_timeout", fp_timeout, 1'b0);
    chk("wb_no_fpu_flush", fpu_flush, 1'b0);
    step();
    chk("wb_pulse_end", fp_wb_valid, 1'b0);
  endtask

  initial begin
    vecs[0] = '{P_ADD, 5'd5,  32'h3F800000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000, 1'b0,
                4'd2, 1'b0, 32'h0, 32'h3F800000, 32'h40000000};
    vecs[1] = '{P_SUB, 5'd7,  32'h40400000, 32'h3F800000, 3'd1, 32'h40000000, 5'b00001, 1'b0,
                4'd2, 1'b1, 32'h0, 32'h40400000, 32'h3F800000};
    vecs[2] = '{P_MUL, 5'd31, 32'h40000000, 32'h40400000, 3'd2, 32'h40C00000, 5'b00000, 1'b0,
                4'd3, 1'b0, 32'h40000000, 32'h40400000, 32'h0};
    vecs[3] = '{P_DIV, 5'd1,  32'h3F800000, 32'h00000000, 3'd3, 32'h7F800000, 5'b01000, 1'b0,
                4'd4, 1'b0, 32'h3F800000, 32'h00000000, 32'h0};
    vecs[4] = '{4'b1100, 5'd2, 32'h1, 32'h2, 3'd0, 32'h0, 5'b0, 1'b1, 4'd0, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[5] = '{4'b0000, 5'd3, 32'h1, 32'h2, 3'd0, 32'h0, 5'b0, 1'b1, 4'd0, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[6] = '{4'b1111, 5'd4, 32'h1, 32'h2, 3'd0, 32'h0, 5'b0, 1'b1, 4'd0, 1'b0, 32'h0, 32'h0, 32'h0};

    rst = 1'b1;
    dec_fp_valid = 1'b0; dec_fp_pkt = 4'd0; dec_fp_rd = 5'd0;
    dec_fp_rs1 = 32'd0; dec_fp_rs2 = 32'd0; dec_frm = 3'd0;
    flush = 1'b0; fflags_clr = 1'b0; fpu_in_ready = 1'b0;
    fpu_out_valid = 1'b0; fpu_result = 32'd0; fpu_status = 5'd0;
    step();
    step();
    chk("rst_busy", fp_busy, 1'b0);
    chk("rst_in_valid", fpu_in_valid, 1'b0);
    chk("rst_out_ready", fpu_out_ready, 1'b0);
    chk("rst_wb_valid", fp_wb_valid, 1'b0);
    chk("rst_fpu_flush", fpu_flush, 1'b0);
    chk("rst_fflags", fflags, 5'd0);
    chk("rst_fpu_op", fpu_op, 4'd0);
    chk("rst_illegal", fp_illegal, 1'b0);
    chk("rst_timeout", fp_timeout, 1'b0);
    rst = 1'b0;
    step();

    // Table-driven single ops and malformed packets.
    for (int i = 0; i < 7; i++) begin
      fpu_in_ready = 1'b1;
      issue(vecs[i].pkt, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].frm, 1'b1);
      if (vecs[i].ill) begin
        chk($sformatf("v%0d_illegal", i), fp_illegal, 1'b1);
        chk($sformatf("v%0d_ill_in_valid", i), fpu_in_valid, 1'b0);
        chk($sformatf("v%0d_ill_busy", i), fp_busy, 1'b0);
        step();
        chk($sformatf("v%0d_illegal_end", i), fp_illegal, 1'b0);
      end else begin
        chk($sformatf("v%0d_busy", i), fp_busy, 1'b1);
        chk($sformatf("v%0d_in_valid", i), fpu_in_valid, 1'b1);
        chk($sformatf("v%0d_op", i), fpu_op, vecs[i].op);
        chk($sformatf("v%0d_mod", i), fpu_op_mod, vecs[i].mod);
        chk($sformatf("v%0d_rnd", i), fpu_rnd, vecs[i].frm);
        chk($sformatf("v%0d_opa", i), fpu_opa, vecs[i].opa);
        chk($sformatf("v%0d_opb", i), fpu_opb, vecs[i].opb);
        chk($sformatf("v%0d_opc", i), fpu_opc, vecs[i].opc);
        complete(vecs[i].res, vecs[i].st, 1'b0, vecs[i].rd, 1);
      end
    end

    // Sub stalled five cycles by in_ready, then flushed while BUSY with a response present.
    fpu_in_ready = 1'b0;
    issue(P_SUB, 5'd9, 32'hC0000000, 32'h3F000000, 3'd4, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("stall_in_valid", fpu_in_valid, 1'b1);
      chk("stall_op", {fpu_op, 3'b0, fpu_op_mod}, {4'd2, 3'b0, 1'b1});
      chk("stall_opb", fpu_opb, 32'hC0000000);
      chk("stall_opc", fpu_opc, 32'h3F000000);
      chk("stall_rnd", fpu_rnd, 3'd4);
      step();
    end
    fpu_in_ready = 1'b1;
    step();
    chk("stall_busy_state", fpu_out_ready, 1'b1);
    flush = 1'b1; fpu_out_valid = 1'b1; fpu_status = 5'b11111; fpu_result = 32'hDEADBEEF;
    step();
    flush = 1'b0; fpu_out_valid = 1'b0;
    chk("flush_pulse", fpu_flush, 1'b1);
    chk("flush_no_wb", fp_wb_valid, 1'b0);
    chk("flush_idle", fp_busy, 1'b0);
    chk("flush_fflags", fflags, exp_fflags);
    step();
    chk("flush_pulse_end", fpu_flush, 1'b0);
    issue(P_ADD, 5'd12, 32'h1, 32'h2, 3'd0, 1'b0);
    chk("post_flush_accept", fp_busy, 1'b1);
    complete(32'h00000003, 5'b00000, 1'b0, 5'd12, 1);

    // Flush in IDLE blocks accept without an FPU kill pulse.
    flush = 1'b1;
    issue(P_MUL, 5'd3, 32'h5, 32'h6, 3'd0, 1'b0);
    flush = 1'b0;
    chk("idle_flush_no_accept", fp_busy, 1'b0);
    chk("idle_flush_no_pulse", fpu_flush, 1'b0);

    // Watchdog: no response, expires after 8 cycles outstanding.
    fpu_in_ready = 1'b1;
    issue(P_MUL, 5'd20, 32'h7, 32'h8, 3'd0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("wd_busy_c%0d", k), fp_busy, 1'b1);
      chk($sformatf("wd_no_timeout_c%0d", k), fp_timeout, 1'b0);
      step();
    end
    chk("wd_timeout", fp_timeout, 1'b1);
    chk("wd_fpu_flush", fpu_flush, 1'b1);
    chk("wd_idle", fp_busy, 1'b0);
    chk("wd_no_wb", fp_wb_valid, 1'b0);
    step();
    chk("wd_timeout_end", fp_timeout, 1'b0);
    chk("wd_flush_end", fpu_flush, 1'b0);

    // Response on the 8th cycle wins over the watchdog.
    issue(P_DIV, 5'd21, 32'h9, 32'hA, 3'd0, 1'b0);
    complete(32'h12345678, 5'b00010, 1'b0, 5'd21, 6);

    // Sticky flags: set survives a same-cycle clear.
    issue(P_ADD, 5'd6, 32'h1, 32'h1, 3'd0, 1'b1);
    complete(32'h2, 5'b00001, 1'b0, 5'd6, 1);
    issue(P_ADD, 5'd6, 32'h1, 32'h1, 3'd0, 1'b0);
    complete(32'h2, 5'b10000, 1'b1, 5'd6, 1);
    chk("sticky_hold", fflags, 5'b10000);

    // Reset in the middle of an op.
    issue(P_MUL, 5'd8, 32'h3, 32'h4, 3'd0, 1'b0);
    step();
    #2 rst = 1'b1;
    #1;
    chk("midrst_idle", fp_busy, 1'b0);
    chk("midrst_out_ready", fpu_out_ready, 1'b0);
    chk("midrst_fflags", fflags, 5'd0);
    chk("midrst_no_flush", fpu_flush, 1'b0);
    step();
    rst = 1'b0;
    exp_fflags = 5'd0;
    step();
    chk("postrst_no_wb", fp_wb_valid, 1'b0);
    chk("postrst_no_flush", fpu_flush, 1'b0);
    chk("postrst_idle", fp_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
